// File: rtl/axi_slv_ar_arbiter_if.sv
// Bus bundle between the crossbar masters, the per-slave AR arbiter and the
// slave. Handshake rule for every channel: a transfer happens on a rising
// aclk edge where valid and ready are both high; once valid is raised the
// payload stays stable and valid stays high until that edge, and ready may
// depend combinationally on valid.
interface axi_slv_ar_arbiter_if #(
  parameter int MST_NUM    = 4,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int MIDX_W     = $clog2(MST_NUM)
);
  // Master-facing AR channel (flattened per master)
  logic [MST_NUM-1:0]            mst_arvalid;
  logic [MST_NUM-1:0]            mst_arready;
  logic [MST_NUM*AXI_ADDR_W-1:0] mst_araddr;
  logic [MST_NUM*4-1:0]          mst_arlen;
  logic [MST_NUM*AXI_ID_W-1:0]   mst_arid;

  // Slave-facing AR channel
  logic                  slv_arvalid;
  logic                  slv_arready;
  logic [AXI_ADDR_W-1:0] slv_araddr;
  logic [3:0]            slv_arlen;
  logic [AXI_ID_W-1:0]   slv_arid;
  logic [MIDX_W-1:0]     slv_armst;

  // R channel routing controls
  logic               slv_rvalid;
  logic               slv_rready;
  logic               slv_rlast;
  logic [MST_NUM-1:0] mst_rvalid;
  logic [MST_NUM-1:0] mst_rready;

  // Arbiter view
  modport slave (
    input  mst_arvalid, mst_araddr, mst_arlen, mst_arid,
    input  slv_arready, slv_rvalid, slv_rlast, mst_rready,
    output mst_arready, slv_arvalid, slv_araddr, slv_arlen, slv_arid,
    output slv_armst, slv_rready, mst_rvalid
  );

  // Environment view (masters plus the slave)
  modport master (
    output mst_arvalid, mst_araddr, mst_arlen, mst_arid,
    output slv_arready, slv_rvalid, slv_rlast, mst_rready,
    input  mst_arready, slv_arvalid, slv_araddr, slv_arlen, slv_arid,
    input  slv_armst, slv_rready, mst_rvalid
  );
endinterface

// File: rtl/axi_slv_ar_arbiter.sv
// Round-robin arbiter sharing one slave AR channel among MST_NUM masters.
// A grant is held until the slave accepts it, granted master indices are
// queued in order, and the queue head steers the slave's R beats back to the
// owning master. Outstanding bursts are capped at SLV_OSTDREQ_NUM.
module axi_slv_ar_arbiter #(
  parameter int MST_NUM         = 4,
  parameter int AXI_ID_W        = 4,
  parameter int AXI_ADDR_W      = 32,
  parameter int SLV_OSTDREQ_NUM = 4,
  localparam int MIDX_W         = $clog2(MST_NUM),
  localparam int CNT_W          = $clog2(SLV_OSTDREQ_NUM) + 1,
  localparam int PTR_W          = $clog2(SLV_OSTDREQ_NUM)
) (
  input  logic                 aclk,
  input  logic                 srst,
  axi_slv_ar_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     ostd_cnt,
  output logic                 rsp_err,
  output logic                 arb_state   // 0 = IDLE, 1 = HOLD
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t state_q, state_d;

  logic [MIDX_W-1:0]     rr_ptr_q;
  logic [MIDX_W-1:0]     winner;
  logic [MIDX_W-1:0]     cand;
  logic                  found;
  logic                  not_full;
  logic                  accept;

  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [3:0]            arlen_q;
  logic [AXI_ID_W-1:0]   arid_q;
  logic [MIDX_W-1:0]     armst_q;

  logic [MIDX_W-1:0]     fifo_mem [SLV_OSTDREQ_NUM];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  empty;
  logic [MIDX_W-1:0]     head;
  logic                  push;
  logic                  pop;
  logic                  err_q;

  // Index that is `off` places above `base`, wrapping at MST_NUM
  function automatic logic [MIDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= MST_NUM) s = s - MST_NUM;
    return MIDX_W'(s);
  endfunction

  // Round-robin search from rr_ptr upward; accept is gated on the registered count
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < MST_NUM; k++) begin
      cand = wrap_idx(int'(rr_ptr_q), k);
      if (!found && bus.mst_arvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    not_full = (cnt_q != CNT_W'(SLV_OSTDREQ_NUM));
    accept   = (state_q == S_IDLE) && found && not_full;
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: IDLE grants, HOLD waits for the slave to take the request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_HOLD;
      S_HOLD:  if (bus.slv_arready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: one-hot master ready while granting, slave valid while holding
  always_comb begin
    bus.mst_arready = '0;
    if (accept) bus.mst_arready[winner] = 1'b1;
    bus.slv_arvalid = (state_q == S_HOLD);
    arb_state       = (state_q == S_HOLD);
  end

  // Latch the winner's request payload and advance the round-robin pointer
  always_ff @(posedge aclk) begin
    if (srst) begin
      rr_ptr_q <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      armst_q  <= '0;
    end else if (accept) begin
      rr_ptr_q <= (winner == MIDX_W'(MST_NUM - 1)) ? '0 : winner + 1'b1;
      araddr_q <= bus.mst_araddr[winner*AXI_ADDR_W +: AXI_ADDR_W];
      arlen_q  <= bus.mst_arlen[winner*4 +: 4];
      arid_q   <= bus.mst_arid[winner*AXI_ID_W +: AXI_ID_W];
      armst_q  <= winner;
    end
  end

  assign bus.slv_araddr = araddr_q;
  assign bus.slv_arlen  = arlen_q;
  assign bus.slv_arid   = arid_q;
  assign bus.slv_armst  = armst_q;

  // R routing from the head of the in-order grant queue
  always_comb begin
    empty          = (cnt_q == '0);
    head           = fifo_mem[rd_ptr_q];
    bus.slv_rready = !empty && bus.mst_rready[head];
    for (int i = 0; i < MST_NUM; i++) begin
      bus.mst_rvalid[i] = bus.slv_rvalid && !empty && (head == MIDX_W'(i));
    end
    push = accept;
    pop  = bus.slv_rvalid && bus.slv_rready && bus.slv_rlast;
  end

  // Grant queue storage; contents are don't-care while empty
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q] <= winner;
  end

  // Queue pointers, outstanding count and the sticky stray-response flag
  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (bus.slv_rvalid && empty) err_q <= 1'b1;
    end
  end

  assign ostd_cnt = cnt_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_axi_slv_ar_arbiter.sv
// Directed bench for axi_slv_ar_arbiter: single grant, round-robin order,
// outstanding cap, R routing with backpressure, simultaneous push/pop,
// payload stability under slave stall, stray response and mid-HOLD reset.
module tb_axi_slv_ar_arbiter;
  localparam int MST_NUM = 4;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int OSTD    = 4;
  localparam int CNT_W   = $clog2(OSTD) + 1;

  logic             aclk;
  logic             srst;
  logic [CNT_W-1:0] ostd_cnt;
  logic             rsp_err;
  logic             arb_state;

  int checks   = 0;
  int failures = 0;

  axi_slv_ar_arbiter_if #(
    .MST_NUM(MST_NUM), .AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W)
  ) bus ();

  axi_slv_ar_arbiter #(
    .MST_NUM(MST_NUM), .AXI_ID_W(ID_W), .AXI_ADDR_W(ADDR_W), .SLV_OSTDREQ_NUM(OSTD)
  ) dut (
    .aclk      (aclk),
    .srst      (srst),
    .bus       (bus),
    .ostd_cnt  (ostd_cnt),
    .rsp_err   (rsp_err),
    .arb_state (arb_state)
  );

  // Clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance one cycle and sample 1 time unit after the edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] id);
    bus.mst_araddr[m*ADDR_W +: ADDR_W] = addr;
    bus.mst_arlen[m*4 +: 4]            = len;
    bus.mst_arid[m*ID_W +: ID_W]       = id;
  endtask

  task automatic clear_inputs();
    bus.mst_arvalid = '0;
    bus.mst_araddr  = '0;
    bus.mst_arlen   = '0;
    bus.mst_arid    = '0;
    bus.slv_arready = 1'b0;
    bus.slv_rvalid  = 1'b0;
    bus.slv_rlast   = 1'b0;
    bus.mst_rready  = '0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    clear_inputs();
    tick();
    tick();
    srst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_arvalid", bus.slv_arvalid, 0);
    chk("rst_araddr", bus.slv_araddr, 0);
    chk("rst_arlen", bus.slv_arlen, 0);
    chk("rst_arid", bus.slv_arid, 0);
    chk("rst_armst", bus.slv_armst, 0);
    chk("rst_ostd", ostd_cnt, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_state", arb_state, 0);

    // ---------------- single request from m1
    bus.slv_arready = 1'b1;
    set_req(1, 32'h100, 4'd3, 4'd5);
    bus.mst_arvalid = 4'b0010;
    #1;
    chk("single_arready", bus.mst_arready, 4'b0010);
    tick();
    bus.mst_arvalid = '0;
    #1;
    chk("single_arvalid", bus.slv_arvalid, 1);
    chk("single_araddr", bus.slv_araddr, 32'h100);
    chk("single_arlen", bus.slv_arlen, 3);
    chk("single_arid", bus.slv_arid, 5);
    chk("single_armst", bus.slv_armst, 1);
    chk("single_state", arb_state, 1);
    tick();
    chk("single_drop", bus.slv_arvalid, 0);
    chk("single_ostd", ostd_cnt, 1);
    // return its single-beat response
    bus.slv_rvalid = 1'b1;
    bus.slv_rlast  = 1'b1;
    bus.mst_rready = 4'b0010;
    #1;
    chk("single_rvalid", bus.mst_rvalid, 4'b0010);
    chk("single_rready", bus.slv_rready, 1);
    tick();
    clear_inputs();
    #1;
    chk("single_drain", ostd_cnt, 0);

    // ---------------- round robin and outstanding cap
    do_reset();
    for (int m = 0; m < MST_NUM; m++)
      set_req(m, 32'h1000 + 32'(m * 16), 4'(m), 4'(m + 8));
    bus.mst_arvalid = 4'b1111;
    bus.slv_arready = 1'b1;
    for (int g = 0; g < MST_NUM; g++) begin
      #1;
      chk("rr_grant", bus.mst_arready, 64'(1) << g);
      tick();
      chk("rr_hold_block", bus.mst_arready, 0);
      chk("rr_armst", bus.slv_armst, 64'(g));
      chk("rr_araddr", bus.slv_araddr, 64'(32'h1000 + g * 16));
      chk("rr_arid", bus.slv_arid, 64'(g + 8));
      tick();
    end
    chk("cap_ostd", ostd_cnt, 4);
    chk("cap_block", bus.mst_arready, 0);
    tick();
    chk("cap_block2", bus.mst_arready, 0);
    // one burst back to m0 (queue head) while still full
    bus.slv_rvalid = 1'b1;
    bus.slv_rlast  = 1'b1;
    bus.mst_rready = 4'b1111;
    #1;
    chk("cap_rvalid", bus.mst_rvalid, 4'b0001);
    chk("cap_rready", bus.slv_rready, 1);
    chk("cap_pop_noaccept", bus.mst_arready, 0);
    tick();
    bus.slv_rvalid = 1'b0;
    bus.slv_rlast  = 1'b0;
    bus.mst_rready = '0;
    #1;
    chk("cap_ostd3", ostd_cnt, 3);
    chk("cap_fifth", bus.mst_arready, 4'b0001);
    tick();
    chk("cap_fifth_mst", bus.slv_armst, 0);
    chk("cap_ostd4", ostd_cnt, 4);
    tick();

    // ---------------- R routing with backpressure
    do_reset();
    bus.slv_arready = 1'b1;
    set_req(2, 32'h200, 4'd1, 4'd2);
    set_req(0, 32'h300, 4'd0, 4'd1);
    bus.mst_arvalid = 4'b0100;
    #1;
    chk("route_g2", bus.mst_arready, 4'b0100);
    tick();
    bus.mst_arvalid = 4'b0001;
    tick();
    #1;
    chk("route_g0", bus.mst_arready, 4'b0001);
    tick();
    bus.mst_arvalid = '0;
    tick();
    chk("route_ostd2", ostd_cnt, 2);
    bus.slv_rvalid = 1'b1;
    bus.slv_rlast  = 1'b0;
    bus.mst_rready = 4'b1011;
    #1;
    chk("route_bp_rvalid", bus.mst_rvalid, 4'b0100);
    chk("route_bp_rready", bus.slv_rready, 0);
    tick();
    bus.mst_rready = 4'b1111;
    #1;
    chk("route_b1_rvalid", bus.mst_rvalid, 4'b0100);
    chk("route_b1_rready", bus.slv_rready, 1);
    tick();
    bus.slv_rlast = 1'b1;
    #1;
    chk("route_b2_rvalid", bus.mst_rvalid, 4'b0100);
    tick();
    chk("route_ostd1", ostd_cnt, 1);
    chk("route_b3_rvalid", bus.mst_rvalid, 4'b0001);
    chk("route_b3_rready", bus.slv_rready, 1);
    tick();
    bus.slv_rvalid = 1'b0;
    bus.slv_rlast  = 1'b0;
    bus.mst_rready = '0;
    #1;
    chk("route_ostd0", ostd_cnt, 0);
    chk("route_idle_rvalid", bus.mst_rvalid, 0);

    // ---------------- simultaneous push and pop (rr_ptr is 1 here)
    bus.mst_arvalid = 4'b0010;
    #1;
    chk("sim_g1", bus.mst_arready, 4'b0010);
    tick();
    bus.mst_arvalid = 4'b1000;
    tick();
    #1;
    chk("sim_g3", bus.mst_arready, 4'b1000);
    tick();
    bus.mst_arvalid = 4'b0001;
    tick();
    chk("sim_ostd2", ostd_cnt, 2);
    bus.slv_rvalid = 1'b1;
    bus.slv_rlast  = 1'b1;
    bus.mst_rready = 4'b1111;
    #1;
    chk("sim_grant", bus.mst_arready, 4'b0001);
    chk("sim_rvalid", bus.mst_rvalid, 4'b0010);
    tick();
    bus.slv_rvalid  = 1'b0;
    bus.slv_rlast   = 1'b0;
    bus.mst_rready  = '0;
    bus.mst_arvalid = '0;
    #1;
    chk("sim_ostd_same", ostd_cnt, 2);
    tick();

    // ---------------- payload stable while the slave stalls
    bus.slv_arready = 1'b0;
    set_req(2, 32'h2AB0, 4'd7, 4'hC);
    bus.mst_arvalid = 4'b0100;
    #1;
    chk("stall_grant", bus.mst_arready, 4'b0100);
    tick();
    set_req(2, 32'hDEAD, 4'd1, 4'h1);
    bus.mst_arvalid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_arvalid", bus.slv_arvalid, 1);
      chk("stall_araddr", bus.slv_araddr, 32'h2AB0);
      chk("stall_arlen", bus.slv_arlen, 7);
      chk("stall_arid", bus.slv_arid, 4'hC);
      chk("stall_armst", bus.slv_armst, 2);
      chk("stall_block", bus.mst_arready, 0);
      tick();
    end
    bus.mst_arvalid = '0;
    bus.slv_arready = 1'b1;
    tick();
    chk("stall_release", bus.slv_arvalid, 0);
    chk("stall_ostd3", ostd_cnt, 3);

    // ---------------- stray response and reset mid-HOLD
    do_reset();
    bus.slv_rvalid = 1'b1;
    bus.slv_rlast  = 1'b1;
    bus.mst_rready = 4'b1111;
    #1;
    chk("err_rready", bus.slv_rready, 0);
    chk("err_rvalid", bus.mst_rvalid, 0);
    tick();
    bus.slv_rvalid = 1'b0;
    bus.slv_rlast  = 1'b0;
    chk("err_set", rsp_err, 1);
    tick();
    chk("err_sticky", rsp_err, 1);
    chk("err_ostd", ostd_cnt, 0);
    set_req(3, 32'h4440, 4'd2, 4'd3);
    bus.mst_arvalid = 4'b1000;
    tick();
    bus.mst_arvalid = '0;
    chk("mid_hold", bus.slv_arvalid, 1);
    chk("mid_ostd", ostd_cnt, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("mid_rst_arvalid", bus.slv_arvalid, 0);
    chk("mid_rst_ostd", ostd_cnt, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_araddr", bus.slv_araddr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_slv_ar_arbiter.md
Name: axi_slv_ar_arbiter

Overview:
- Round-robin arbiter that shares one slave's AR channel among MST_NUM masters in the crossbar.
- Holds each grant until the slave accepts the request, which keeps AXI valid stable.
- Keeps an in-order FIFO of granted master indices and uses it to route the slave's R beats back to the right master. The slave is assumed to return R bursts in AR acceptance order, as the slave-side responder does.
- Caps outstanding reads at SLV_OSTDREQ_NUM.

Parameters:
- MST_NUM, 4, number of requesting masters (≥2).
- AXI_ID_W, 4, ARID width.
- AXI_ADDR_W, 32, ARADDR width.
- SLV_OSTDREQ_NUM, 4, maximum outstanding read bursts at the slave (power of 2).
- MIDX_W = $clog2(MST_NUM), derived, master index width.

Ports:
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- mst_arvalid  in  MST_NUM  per-master AR valid.
- mst_arready  out  MST_NUM  per-master AR ready.
- mst_araddr  in  MST_NUM*AXI_ADDR_W  flattened; master i at [i*AXI_ADDR_W +: AXI_ADDR_W].
- mst_arlen  in  MST_NUM*4  flattened burst lengths.
- mst_arid  in  MST_NUM*AXI_ID_W  flattened IDs.
- slv_arvalid  out  1  registered AR valid to the slave.
- slv_arready  in  1  slave AR ready.
- slv_araddr  out  AXI_ADDR_W  registered.
- slv_arlen  out  4  registered.
- slv_arid  out  AXI_ID_W  registered.
- slv_armst  out  MIDX_W  index of the master owning the presented request.
- slv_rvalid  in  1  slave R valid.
- slv_rready  out  1  R ready to the slave.
- slv_rlast  in  1  slave R last.
- mst_rvalid  out  MST_NUM  routed R valid.
- mst_rready  in  MST_NUM  per-master R ready.
- ostd_cnt  out  $clog2(SLV_OSTDREQ_NUM)+1  outstanding bursts.
- rsp_err  out  1  sticky: R beat arrived with no outstanding burst.

Behaviour:
- Reset (srst=1 at a clock edge) clears:
  - FSM to IDLE, rr_ptr=0, ostd_cnt=0, FIFO empty, rsp_err=0.
  - slv_arvalid=0; slv_araddr, slv_arlen, slv_arid, slv_armst = 0.
- A reset mid-burst drops all in-flight state. Masters must also be reset.
- FSM IDLE:
  - Accept condition: any mst_arvalid AND ostd_cnt<SLV_OSTDREQ_NUM.
  - Winner is the first requester searching from rr_ptr upward, wrapping at MST_NUM-1→0.
  - mst_arready[winner]=1 combinationally in that cycle; all other mst_arready=0.
  - On the edge: latch the winner's addr/len/id into the slv_ar* registers, slv_armst=winner, push winner into the FIFO, ostd_cnt+1, rr_ptr=winner+1 (mod MST_NUM), go to HOLD.
- FSM HOLD:
  - slv_arvalid=1; all mst_arready=0; payload stable.
  - On slv_arready: slv_arvalid drops next cycle and the FSM returns to IDLE.
- AR latency: master handshake at cycle N → slv_arvalid=1 at N+1. Maximum AR issue rate is one request per 2 cycles.
- Full condition: ostd_cnt==SLV_OSTDREQ_NUM blocks all mst_arready. The FIFO never overflows.
- R routing, with head = FIFO head index:
  - mst_rvalid[i] = slv_rvalid & !empty & (head==i).
  - slv_rready = !empty & mst_rready[head].
  - R data, id and resp are broadcast outside this block.
- Pop on slv_rvalid & slv_rready & slv_rlast. ostd_cnt then decrements.
- Push and pop in the same cycle: ostd_cnt unchanged; FIFO pointers both advance, wrapping mod SLV_OSTDREQ_NUM.
- Push and pop are legal when full if a pop frees space in the same cycle? No: accept is gated on the registered count, so a simultaneous pop does not allow a push when full.
- slv_rvalid while FIFO empty: slv_rready=0, mst_rvalid=0, rsp_err set until srst.
- ostd_cnt never wraps; both pointers are MIDX-independent, using a $clog2(SLV_OSTDREQ_NUM)-bit wrap.

Test Plan:
- Single request: reset, then m1 arvalid with addr=0x100, len=3, id=5 → mst_arready[1]=1 at cycle 0; slv_arvalid=1, slv_araddr=0x100, slv_armst=1 at cycle 1. With slv_arready tied 1, slv_arvalid=0 at cycle 2 and ostd_cnt=1.
- Round-robin fairness: all 4 masters request continuously, slv_arready=1 → grant order 0,1,2,3,0; one grant every 2 cycles.
- Outstanding cap: 4 accepted with no R returned → ostd_cnt=4 and a 5th request sees mst_arready=0. One R burst with rlast handshake → ostd_cnt=3 and the 5th request is granted the next cycle.
- R routing: grants m2 (len=1) then m0 (len=0); slave returns 3 beats → mst_rvalid[2] on beats 1–2, mst_rvalid[0] on beat 3. With mst_rready[2]=0 held, slv_rready=0 (backpressure).
- Simultaneous events: rlast pop in the same cycle as a new grant with ostd_cnt=2 → ostd_cnt stays 2. Separately, hold slv_arready=0 for 5 cycles → slv_ar* payload stays unchanged throughout.
- Error and reset: slv_rvalid=1 with the FIFO empty → rsp_err=1, sticky. Then srst mid-HOLD → next cycle slv_arvalid=0, ostd_cnt=0, rsp_err=0.
